// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row scan, column synchroniser, press/release
// debounce and key-code mapping with a delayed strobe.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000,
  parameter int EN_PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       kbEN,
  output logic [3:0] pressedkey,
  output logic       key_held
);

  localparam int MAXV0 = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int MAXV  = (MAXV0 > EN_PULSE_LEN) ? MAXV0 : EN_PULSE_LEN;
  localparam int CW    = $clog2(MAXV) + 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] EN_LEN    = CW'(EN_PULSE_LEN);

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    LOAD,
    STROBE,
    WAIT_RELEASE
  } state_t;

  state_t      state;
  logic [3:0]  sync1;
  logic [3:0]  col_s;
  logic [1:0]  row_idx;
  logic [1:0]  key_col;
  logic [3:0]  entry_pat;
  logic [CW-1:0] cnt;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    row_drive = ~(4'b0001 << r);
  endfunction

  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0])      low_col = 2'd0;
    else if (!c[1]) low_col = 2'd1;
    else if (!c[2]) low_col = 2'd2;
    else            low_col = 2'd3;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'd0;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd12;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd13;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd14;
      4'hC: code = 4'd11;
      4'hD: code = 4'd0;
      4'hE: code = 4'd10;
      4'hF: code = 4'd15;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      col_s <= '1;
    end else begin
      sync1 <= col_n;
      col_s <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SCAN;
      row_idx    <= '0;
      row_n      <= 4'b1110;
      key_col    <= '0;
      entry_pat  <= '1;
      cnt        <= '0;
      kbEN       <= 1'b0;
      pressedkey <= '0;
      key_held   <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (col_s != 4'b1111) begin
              key_col   <= low_col(col_s);
              entry_pat <= col_s;
              state     <= DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
              row_n   <= row_drive(row_idx + 2'd1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A pattern change restarts the dwell on the same row rather than moving on.
        DEBOUNCE: begin
          if (col_s != entry_pat) begin
            cnt   <= '0;
            state <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == DEB_LAST) state <= LOAD;
          end
        end

        // Code lands one clock ahead of the strobe so the consumer latches a settled value.
        LOAD: begin
          pressedkey <= key_code(row_idx, key_col);
          key_held   <= 1'b1;
          cnt        <= '0;
          state      <= STROBE;
        end

        STROBE: begin
          if (cnt == EN_LEN) begin
            kbEN  <= 1'b0;
            cnt   <= '0;
            state <= WAIT_RELEASE;
          end else begin
            kbEN <= 1'b1;
            cnt  <= cnt + 1'b1;
          end
        end

        WAIT_RELEASE: begin
          if (col_s != 4'b1111) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            key_held <= 1'b0;
            cnt      <= '0;
            row_idx  <= row_idx + 2'd1;
            row_n    <= row_drive(row_idx + 2'd1);
            state    <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          kbEN  <= 1'b0;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule
